instr_encoder: RTL and testbench

Field-level instruction encoder and issue buffer: the inverse of the decode stage. It accepts opcode/funct/register/immediate fields over a valid/ready handshake and checks them against the supported MIPS subset. Legal requests are packed into 32-bit instruction words, buffered in a small FIFO and issued one per cycle as an instruction plus a chip-enable pulse, in the form the decode stage consumes. It sits between the test/program source and the decode stage and tags each issued word with its PC.

---
 rtl/instr_encoder_pkg.sv | 51 +++++
 rtl/instr_encoder_fifo.sv | 71 +++++++
 rtl/instr_encoder.sv | 137 +++++++++++++
 tb/tb_instr_encoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared field widths, opcode/funct encodings and the
// legality rule for the instruction encoder.
//   OPCODE_WIDTH / FUNCT_WIDTH / SHAMT_WIDTH : instruction field widths
//   PC_STEP                                  : byte distance between issued PCs
//   OP_* / FN_*                              : supported MIPS subset encodings
//   is_legal()                               : opcode/funct acceptance check
package instr_encoder_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int FUNCT_WIDTH  = 6;
  localparam int SHAMT_WIDTH  = 5;
  localparam int PC_STEP      = 4;

  localparam logic [OPCODE_WIDTH-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI   = 6'h08;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDIU  = 6'h09;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTI   = 6'h0A;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLTIU  = 6'h0B;
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OPCODE_WIDTH-1:0] OP_ORI    = 6'h0D;
  localparam logic [OPCODE_WIDTH-1:0] OP_XORI   = 6'h0E;
  localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 6'h23;
  localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 6'h2B;

  localparam logic [FUNCT_WIDTH-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_WIDTH-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_WIDTH-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_WIDTH-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_WIDTH-1:0] FN_XOR = 6'h26;

  // funct only matters for R-type; immediate forms ignore it entirely.
  function automatic logic is_legal(input logic [OPCODE_WIDTH-1:0] opcode,
                                    input logic [FUNCT_WIDTH-1:0]  funct);
    logic ok;
    ok = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR: ok = 1'b1;
          default:                               ok = 1'b0;
        endcase
      end
      OP_LOAD, OP_STORE, OP_BRANCH, OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:        ok = 1'b1;
      default:                                   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/instr_encoder_fifo.sv
// enc_fifo: synchronous DEPTH x WIDTH FIFO buffering packed instruction words.
//   clk, rst         : clock, synchronous active-high reset (empties FIFO)
//   push, wr_data    : write request and data (ignored when full)
//   pop, rd_data     : read request (ignored when empty); rd_data shows head
//   full, empty      : occupancy flags
//   count            : occupancy, 0..DEPTH
module enc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: checks instruction field requests against the supported MIPS
// subset, packs legal ones into instruction words, buffers them and issues one
// per cycle with a chip-enable pulse and the word's PC.
//   e_clk, e_rst                   : clock, synchronous active-high reset
//   e_i_valid / e_o_ready          : request handshake
//   e_i_opcode, e_i_funct,
//   e_i_addr_rs/rt/rd, e_i_imm     : instruction fields
//   e_i_stall                      : blocks issue while high
//   e_i_pc_load, e_i_pc_base       : PC counter load
//   e_o_instr, e_o_pc, e_o_ce      : issued word, its PC, one-cycle issue pulse
//   e_o_err, e_o_err_cnt           : illegal-request pulse and saturating count
//   e_o_count                      : FIFO occupancy
//
// Handshake: a request transfers on a rising edge where e_i_valid and
// e_o_ready are both high. e_o_ready is low while the FIFO is full or reset is
// asserted; a pop in the same cycle does not raise it. Illegal requests still
// complete the handshake but are dropped and flagged on e_o_err.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int AWIDTH    = 5,
  parameter int IWIDTH    = 32,
  parameter int IMM_WIDTH = 16,
  parameter int DEPTH     = 4,
  parameter int PC_WIDTH  = 32
) (
  input  logic                   e_clk,
  input  logic                   e_rst,
  input  logic                   e_i_valid,
  output logic                   e_o_ready,
  input  logic [5:0]             e_i_opcode,
  input  logic [5:0]             e_i_funct,
  input  logic [AWIDTH-1:0]      e_i_addr_rs,
  input  logic [AWIDTH-1:0]      e_i_addr_rt,
  input  logic [AWIDTH-1:0]      e_i_addr_rd,
  input  logic [IMM_WIDTH-1:0]   e_i_imm,
  input  logic                   e_i_stall,
  input  logic                   e_i_pc_load,
  input  logic [PC_WIDTH-1:0]    e_i_pc_base,
  output logic [IWIDTH-1:0]      e_o_instr,
  output logic                   e_o_ce,
  output logic [PC_WIDTH-1:0]    e_o_pc,
  output logic                   e_o_err,
  output logic [7:0]             e_o_err_cnt,
  output logic [$clog2(DEPTH):0] e_o_count
);

  localparam logic [PC_WIDTH-1:0] PC_INC = PC_WIDTH'(PC_STEP);

  logic                  fifo_full, fifo_empty;
  logic [IWIDTH-1:0]     fifo_rd_data;
  logic                  accept, legal, push, pop;
  logic [IWIDTH-1:0]     packed_word;
  logic [PC_WIDTH-1:0]   pc_sel;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
  logic [IWIDTH-1:0]     instr_q, instr_d;
  logic                  ce_q, ce_d;
  logic                  err_q, err_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  assign e_o_ready = !fifo_full && !e_rst;
  assign accept    = e_i_valid && e_o_ready;
  assign legal     = is_legal(e_i_opcode, e_i_funct);
  assign push      = accept && legal;
  // No bypass: a word must sit in the FIFO for at least one edge before issue.
  assign pop       = !e_i_stall && !fifo_empty;

  always_comb begin
    packed_word = '0;
    if (e_i_opcode == OP_RTYPE) begin
      packed_word = IWIDTH'({e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_addr_rd,
                             {SHAMT_WIDTH{1'b0}}, e_i_funct});
    end else begin
      packed_word = IWIDTH'({e_i_opcode, e_i_addr_rs, e_i_addr_rt, e_i_imm});
    end
  end

  // A PC load wins over the increment and also tags a same-cycle pop.
  always_comb begin
    pc_sel    = e_i_pc_load ? e_i_pc_base : pc_q;
    pc_d      = pc_sel;
    out_pc_d  = out_pc_q;
    instr_d   = instr_q;
    ce_d      = 1'b0;
    if (pop) begin
      instr_d  = fifo_rd_data;
      out_pc_d = pc_sel;
      ce_d     = 1'b1;
      pc_d     = pc_sel + PC_INC;
    end
    err_d     = accept && !legal;
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge e_clk) begin
    if (e_rst) begin
      pc_q      <= '0;
      out_pc_q  <= '0;
      instr_q   <= '0;
      ce_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      out_pc_q  <= out_pc_d;
      instr_q   <= instr_d;
      ce_q      <= ce_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  enc_fifo #(
    .WIDTH (IWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (e_clk),
    .rst     (e_rst),
    .push    (push),
    .wr_data (packed_word),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (e_o_count)
  );

  assign e_o_instr   = instr_q;
  assign e_o_pc      = out_pc_q;
  assign e_o_ce      = ce_q;
  assign e_o_err     = err_q;
  assign e_o_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed scenarios with literal expectations plus a long
// randomized run, all checked every cycle against a queue-based model.
module tb_instr_encoder;

  localparam int AW    = 5;
  localparam int IW    = 32;
  localparam int IMMW  = 16;
  localparam int DEPTH = 4;
  localparam int PCW   = 32;

  // ---------------- clock / reset / DUT ----------------
  logic            e_clk = 1'b0;
  logic            e_rst = 1'b1;
  logic            e_i_valid = 1'b0;
  logic            e_o_ready;
  logic [5:0]      e_i_opcode = '0;
  logic [5:0]      e_i_funct = '0;
  logic [AW-1:0]   e_i_addr_rs = '0;
  logic [AW-1:0]   e_i_addr_rt = '0;
  logic [AW-1:0]   e_i_addr_rd = '0;
  logic [IMMW-1:0] e_i_imm = '0;
  logic            e_i_stall = 1'b0;
  logic            e_i_pc_load = 1'b0;
  logic [PCW-1:0]  e_i_pc_base = '0;
  logic [IW-1:0]   e_o_instr;
  logic            e_o_ce;
  logic [PCW-1:0]  e_o_pc;
  logic            e_o_err;
  logic [7:0]      e_o_err_cnt;
  logic [2:0]      e_o_count;

  always #5 e_clk = ~e_clk;

  instr_encoder #(
    .AWIDTH(AW), .IWIDTH(IW), .IMM_WIDTH(IMMW), .DEPTH(DEPTH), .PC_WIDTH(PCW)
  ) dut (
    .e_clk(e_clk), .e_rst(e_rst), .e_i_valid(e_i_valid), .e_o_ready(e_o_ready),
    .e_i_opcode(e_i_opcode), .e_i_funct(e_i_funct),
    .e_i_addr_rs(e_i_addr_rs), .e_i_addr_rt(e_i_addr_rt), .e_i_addr_rd(e_i_addr_rd),
    .e_i_imm(e_i_imm), .e_i_stall(e_i_stall), .e_i_pc_load(e_i_pc_load),
    .e_i_pc_base(e_i_pc_base), .e_o_instr(e_o_instr), .e_o_ce(e_o_ce),
    .e_o_pc(e_o_pc), .e_o_err(e_o_err), .e_o_err_cnt(e_o_err_cnt),
    .e_o_count(e_o_count)
  );

  // ---------------- checking bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [5:0] legal_ops [11] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h09,
                                 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E};
  logic [5:0] legal_fns [5]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26};

  function automatic bit m_legal(input logic [5:0] op, input logic [5:0] fn);
    bit ok = 0;
    for (int i = 0; i < 11; i++) if (op == legal_ops[i]) ok = 1;
    if (op == 6'h00) begin
      ok = 0;
      for (int i = 0; i < 5; i++) if (fn == legal_fns[i]) ok = 1;
    end
    return ok;
  endfunction

  function automatic logic [31:0] m_pack(input logic [5:0] op, input logic [5:0] fn,
                                         input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [15:0] imm);
    logic [31:0] w;
    w = (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16);
    if (op == 6'h00) w = w | (32'(rd) << 11) | 32'(fn);
    else             w = w | 32'(imm);
    return w;
  endfunction

  logic [IW-1:0]  exp_q[$];
  logic [PCW-1:0] m_pc = '0, m_opc = '0, m_base;
  logic [IW-1:0]  m_instr = '0;
  bit             m_ce = 0, m_err = 0, m_acc, m_ok, check_en = 0;
  int             m_err_cnt = 0;

  always @(posedge e_clk) begin
    if (e_rst) begin
      exp_q.delete();
      m_pc = '0; m_opc = '0; m_instr = '0;
      m_ce = 0; m_err = 0; m_err_cnt = 0;
      check_en = 1;
    end else begin
      m_acc  = e_i_valid && (exp_q.size() < DEPTH);
      m_ok   = m_legal(e_i_opcode, e_i_funct);
      m_base = e_i_pc_load ? e_i_pc_base : m_pc;
      m_ce   = 0;
      if (!e_i_stall && exp_q.size() > 0) begin
        m_instr = exp_q.pop_front();
        m_opc   = m_base;
        m_ce    = 1;
        m_pc    = m_base + 32'd4;
      end else begin
        m_pc = m_base;
      end
      if (m_acc && m_ok)
        exp_q.push_back(m_pack(e_i_opcode, e_i_funct, e_i_addr_rs, e_i_addr_rt,
                               e_i_addr_rd, e_i_imm));
      m_err = m_acc && !m_ok;
      if (m_err && m_err_cnt < 255) m_err_cnt++;
    end
  end

  // One compare process, every cycle after the first reset.
  always @(posedge e_clk) begin
    #1;
    if (check_en) begin
      check("cyc_instr",   e_o_instr,   m_instr);
      check("cyc_pc",      e_o_pc,      m_opc);
      check("cyc_ce",      e_o_ce,      m_ce);
      check("cyc_err",     e_o_err,     m_err);
      check("cyc_err_cnt", e_o_err_cnt, m_err_cnt);
      check("cyc_count",   e_o_count,   exp_q.size());
      check("cyc_ready",   e_o_ready,   (exp_q.size() < DEPTH) && !e_rst);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge e_clk);
    e_rst = 1'b1; e_i_valid = 1'b0; e_i_pc_load = 1'b0; e_i_stall = 1'b0;
    @(negedge e_clk);
    e_rst = 1'b0;
  endtask

  // Returns 1 time unit after the accepting edge.
  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rs,
                      input logic [4:0] rt, input logic [4:0] rd, input logic [15:0] imm);
    int n = 0;
    @(negedge e_clk);
    e_i_opcode = op; e_i_funct = fn; e_i_addr_rs = rs; e_i_addr_rt = rt;
    e_i_addr_rd = rd; e_i_imm = imm; e_i_valid = 1'b1;
    while (!e_o_ready && n < 100) begin @(negedge e_clk); n++; end
    if (n >= 100) check("push_timeout", 1, 0);
    @(posedge e_clk);
    #1;
    e_i_valid = 1'b0;
  endtask

  task automatic wait_issue(output logic [31:0] instr, output logic [31:0] pc);
    int n = 0;
    do begin @(posedge e_clk); #1; n++; end while (!e_o_ce && n < 50);
    if (!e_o_ce) check("issue_timeout", 0, 1);
    instr = e_o_instr;
    pc    = e_o_pc;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] wi, wp;
  logic [31:0] words [5];
  int          ce_seen, n5, stall_pct;

  initial begin
    // pin the model against hand-computed encodings
    check("model_rtype", m_pack(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0), 32'h00221820);
    check("model_load",  m_pack(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 16'h0008), 32'h8C850008);
    check("model_illegal_j", m_legal(6'h02, 6'h20), 0);
    check("model_illegal_slt", m_legal(6'h00, 6'h2A), 0);

    repeat (3) @(posedge e_clk);
    @(negedge e_clk);
    e_rst = 1'b0;

    // R-type, 2-cycle latency
    push(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
    check("lat_ce_early", e_o_ce, 0);
    @(posedge e_clk); #1;
    check("lat_ce", e_o_ce, 1);
    check("lat_instr", e_o_instr, 32'h00221820);
    check("lat_pc", e_o_pc, 32'h0);

    // back-to-back LOAD then ADDI
    do_reset();
    push(6'h23, 6'h00, 5'd4, 5'd5, 5'd0, 16'h0008);
    push(6'h08, 6'h00, 5'd0, 5'd2, 5'd0, 16'hFFFF);
    check("b2b_ce0", e_o_ce, 1);
    check("b2b_instr0", e_o_instr, 32'h8C850008);
    check("b2b_pc0", e_o_pc, 32'h0);
    @(posedge e_clk); #1;
    check("b2b_ce1", e_o_ce, 1);
    check("b2b_instr1", e_o_instr, 32'h2002FFFF);
    check("b2b_pc1", e_o_pc, 32'h4);

    // illegal requests
    do_reset();
    push(6'h02, 6'h00, 5'd1, 5'd1, 5'd1, 16'h1234);
    check("ill_err0", e_o_err, 1);
    push(6'h00, 6'h2A, 5'd1, 5'd2, 5'd3, 16'h0);
    check("ill_err1", e_o_err, 1);
    check("ill_cnt", e_o_err_cnt, 8'd2);
    ce_seen = 0;
    repeat (4) begin @(posedge e_clk); #1; if (e_o_ce) ce_seen++; end
    check("ill_no_ce", ce_seen, 0);
    check("ill_err_low", e_o_err, 0);

    // fill under stall, 5th request held, then drain in order
    do_reset();
    e_i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      words[i] = m_pack(6'h0D, 6'h00, 5'(i), 5'(i + 8), 5'd0, 16'(16'hA000 + i));
      push(6'h0D, 6'h00, 5'(i), 5'(i + 8), 5'd0, 16'(16'hA000 + i));
    end
    check("full_ready", e_o_ready, 0);
    check("full_count", e_o_count, 3'd4);
    words[4] = m_pack(6'h00, 6'h26, 5'd7, 5'd8, 5'd9, 16'h0);
    @(negedge e_clk);
    e_i_opcode = 6'h00; e_i_funct = 6'h26; e_i_addr_rs = 5'd7; e_i_addr_rt = 5'd8;
    e_i_addr_rd = 5'd9; e_i_valid = 1'b1;
    @(posedge e_clk); #1;
    check("held_count", e_o_count, 3'd4);
    check("held_ready", e_o_ready, 0);
    @(negedge e_clk);
    e_i_stall = 1'b0;
    fork
      begin
        n5 = 0;
        do begin @(negedge e_clk); n5++; end while (!e_o_ready && n5 < 20);
        @(posedge e_clk); #1;
        e_i_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 5; i++) begin
          wait_issue(wi, wp);
          check("drain_pc", wp, 32'(i * 4));
          check("drain_order", wi, words[i]);
        end
      end
    join

    // PC load coinciding with a pop, then wrap-around
    do_reset();
    e_i_stall = 1'b1;
    push(6'h09, 6'h00, 5'd1, 5'd2, 5'd0, 16'h0001);
    push(6'h0B, 6'h00, 5'd3, 5'd4, 5'd0, 16'h0002);
    @(negedge e_clk);
    e_i_stall = 1'b0; e_i_pc_load = 1'b1; e_i_pc_base = 32'h00400000;
    @(posedge e_clk); #1;
    e_i_pc_load = 1'b0;
    check("load_pc0", e_o_pc, 32'h00400000);
    check("load_ce0", e_o_ce, 1);
    @(posedge e_clk); #1;
    check("load_pc1", e_o_pc, 32'h00400004);
    e_i_stall = 1'b1;
    push(6'h2B, 6'h00, 5'd5, 5'd6, 5'd0, 16'h0010);
    push(6'h04, 6'h00, 5'd7, 5'd8, 5'd0, 16'hFFF0);
    @(negedge e_clk);
    e_i_stall = 1'b0; e_i_pc_load = 1'b1; e_i_pc_base = 32'hFFFFFFFC;
    @(posedge e_clk); #1;
    e_i_pc_load = 1'b0;
    check("wrap_pc0", e_o_pc, 32'hFFFFFFFC);
    @(posedge e_clk); #1;
    check("wrap_pc1", e_o_pc, 32'h00000000);
    check("wrap_instr1", e_o_instr, 32'h10E8FFF0);

    // reset with entries buffered
    push(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    e_i_stall = 1'b1;
    for (int i = 0; i < 3; i++) push(6'h0C, 6'h00, 5'd1, 5'd1, 5'd0, 16'(i));
    check("rst_pre_count", e_o_count, 3'd3);
    @(negedge e_clk);
    e_rst = 1'b1;
    @(posedge e_clk); #1;
    check("rst_instr", e_o_instr, 32'h0);
    check("rst_pc", e_o_pc, 32'h0);
    check("rst_ce", e_o_ce, 0);
    check("rst_err", e_o_err, 0);
    check("rst_err_cnt", e_o_err_cnt, 8'd0);
    check("rst_count", e_o_count, 3'd0);
    check("rst_ready", e_o_ready, 0);
    @(negedge e_clk);
    e_rst = 1'b0; e_i_stall = 1'b0;
    ce_seen = 0;
    repeat (6) begin @(posedge e_clk); #1; if (e_o_ce) ce_seen++; end
    check("rst_no_stale", ce_seen, 0);
    push(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 16'h0);
    wait_issue(wi, wp);
    check("rst_new_pc", wp, 32'h0);
    check("rst_new_instr", wi, 32'h00221820);

    // error counter saturation
    do_reset();
    for (int i = 0; i < 260; i++) push(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 16'h0);
    check("err_sat", e_o_err_cnt, 8'd255);

    // randomized run
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge e_clk);
      stall_pct = ((c / 250) % 2 == 1) ? 75 : 15;
      e_rst       = ($urandom_range(0, 299) == 0);
      e_i_valid   = ($urandom_range(0, 99) < 65);
      e_i_opcode  = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 10)] : 6'($urandom);
      e_i_funct   = ($urandom_range(0, 9) < 7) ? legal_fns[$urandom_range(0, 4)] : 6'($urandom);
      e_i_addr_rs = 5'($urandom);
      e_i_addr_rt = 5'($urandom);
      e_i_addr_rd = 5'($urandom);
      e_i_imm     = 16'($urandom);
      e_i_stall   = ($urandom_range(0, 99) < stall_pct);
      e_i_pc_load = ($urandom_range(0, 99) < 3);
      e_i_pc_base = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF8 : $urandom;
    end
    @(negedge e_clk);
    e_rst = 1'b0; e_i_valid = 1'b0; e_i_stall = 1'b0; e_i_pc_load = 1'b0;
    repeat (10) @(posedge e_clk);
    #2;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
